// File: rtl/vga_rx_monitor_pkg.sv
// Shared definitions for the VGA receive monitor.
//   - 640x480 timing constants and the derived totals / sync start positions
//   - lock FSM state encoding
//   - small counter helpers used by the top
package vga_rx_monitor_pkg;

  localparam int VGA_H_DISPLAY = 640;
  localparam int VGA_H_FRONT   = 16;
  localparam int VGA_H_RETRACE = 96;
  localparam int VGA_H_BACK    = 48;
  localparam int VGA_V_DISPLAY = 480;
  localparam int VGA_V_FRONT   = 10;
  localparam int VGA_V_RETRACE = 2;
  localparam int VGA_V_BACK    = 33;

  localparam int VGA_H_TOTAL  = VGA_H_DISPLAY + VGA_H_FRONT + VGA_H_RETRACE + VGA_H_BACK; // 800
  localparam int VGA_V_TOTAL  = VGA_V_DISPLAY + VGA_V_FRONT + VGA_V_RETRACE + VGA_V_BACK; // 525
  localparam int VGA_HS_START = VGA_H_DISPLAY + VGA_H_FRONT;                              // 656
  localparam int VGA_VS_START = VGA_V_DISPLAY + VGA_V_FRONT;                              // 490

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    ARMED  = 2'd1,
    LOCKED = 2'd2
  } rx_state_e;

  // Increment with wrap back to zero after 'last'.
  function automatic logic [9:0] wrap_inc(input logic [9:0] v, input logic [9:0] last);
    return (v == last) ? 10'd0 : v + 10'd1;
  endfunction

  // Saturating 8-bit increment.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/vga_rx_monitor_sync_edge_detect.sv
// Falling-edge detector for one active-low sync line.
// The previous level is only captured on pixel ticks, so an edge is the
// pair (prev=1, now=0) seen on the same tick.
//   clk, reset  : clock, asynchronous active-low reset (prev resets to 1)
//   tick        : pixel-tick enable
//   sync_n      : sync line being watched
//   fall        : combinational pulse, high on a tick that sees a falling edge
module sync_edge_detect (
  input  logic clk,
  input  logic reset,
  input  logic tick,
  input  logic sync_n,
  output logic fall
);

  logic prev;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)    prev <= 1'b1;
    else if (tick) prev <= sync_n;
  end

  assign fall = tick & prev & ~sync_n;

endmodule

// File: rtl/vga_rx_monitor.sv
// VGA receive monitor: rebuilds (x,y) from hsync/vsync, checks sync edge
// positions, acquires lock and accumulates a per-frame rgb checksum.
//   clk, reset      : clock, asynchronous active-low reset
//   p_pixel         : pixel tick; all sampling is qualified by it
//   hsync, vsync    : active-low syncs
//   rgb             : pixel colour for the coordinate sampled on this tick
//   clr_err         : clears h_err, v_err, error_count
//   x_rx, y_rx      : coordinate of the next sample to arrive
//   locked          : lock acquired
//   pix_valid       : locked and (x_rx,y_rx) in the active area
//   frame_done      : 1-clk pulse after the last active pixel of a locked frame
//   frame_checksum  : rgb sum (mod 2^16) of the last complete locked frame
//   h_err, v_err    : sticky misplaced-edge flags
//   error_count     : saturating count of resync events
module vga_rx_monitor
  import vga_rx_monitor_pkg::*;
#(
  parameter int H_DISPLAY = VGA_H_DISPLAY,
  parameter int H_FRONT   = VGA_H_FRONT,
  parameter int H_RETRACE = VGA_H_RETRACE,
  parameter int H_BACK    = VGA_H_BACK,
  parameter int V_DISPLAY = VGA_V_DISPLAY,
  parameter int V_FRONT   = VGA_V_FRONT,
  parameter int V_RETRACE = VGA_V_RETRACE,
  parameter int V_BACK    = VGA_V_BACK
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        p_pixel,
  input  logic        hsync,
  input  logic        vsync,
  input  logic [11:0] rgb,
  input  logic        clr_err,
  output logic [9:0]  x_rx,
  output logic [9:0]  y_rx,
  output logic        locked,
  output logic        pix_valid,
  output logic        frame_done,
  output logic [15:0] frame_checksum,
  output logic        h_err,
  output logic        v_err,
  output logic [7:0]  error_count
);

  localparam int H_TOTAL  = H_DISPLAY + H_FRONT + H_RETRACE + H_BACK;
  localparam int V_TOTAL  = V_DISPLAY + V_FRONT + V_RETRACE + V_BACK;
  localparam int HS_START = H_DISPLAY + H_FRONT;
  localparam int VS_START = V_DISPLAY + V_FRONT;

  localparam logic [9:0] X_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0] Y_LAST     = 10'(V_TOTAL - 1);
  localparam logic [9:0] HS_X       = 10'(HS_START);
  localparam logic [9:0] HS_X_NEXT  = 10'(HS_START + 1);
  localparam logic [9:0] VS_Y       = 10'(VS_START);
  localparam logic [9:0] X_ACT      = 10'(H_DISPLAY);
  localparam logic [9:0] Y_ACT      = 10'(V_DISPLAY);
  localparam logic [9:0] X_ACT_LAST = 10'(H_DISPLAY - 1);
  localparam logic [9:0] Y_ACT_LAST = 10'(V_DISPLAY - 1);

  rx_state_e   state, state_nxt;
  logic        h_fall, v_fall;
  logic        h_bad, v_ok, v_bad, resync;
  logic        end_tick;
  logic [9:0]  x_nxt, y_nxt;
  logic [15:0] acc;

  sync_edge_detect u_hs (
    .clk    (clk),
    .reset  (reset),
    .tick   (p_pixel),
    .sync_n (hsync),
    .fall   (h_fall)
  );

  sync_edge_detect u_vs (
    .clk    (clk),
    .reset  (reset),
    .tick   (p_pixel),
    .sync_n (vsync),
    .fall   (v_fall)
  );

  // Edge checks use the pre-increment coordinate, i.e. the position of the
  // sample carried by this tick.
  assign h_bad  = h_fall && (x_rx != HS_X);
  assign v_ok   = v_fall && (x_rx == 10'd0) && (y_rx == VS_Y);
  assign v_bad  = v_fall && !v_ok;
  assign resync = h_bad || v_bad;

  assign locked    = (state == LOCKED);
  assign pix_valid = locked && (x_rx < X_ACT) && (y_rx < Y_ACT);
  assign end_tick  = p_pixel && locked && (x_rx == X_ACT_LAST) && (y_rx == Y_ACT_LAST);

  // Coordinate counter. A bad vsync realigns both axes and takes precedence
  // over a bad hsync on the same tick.
  always_comb begin
    x_nxt = x_rx;
    y_nxt = y_rx;
    if (p_pixel) begin
      if (v_bad) begin
        x_nxt = 10'd1;
        y_nxt = VS_Y;
      end else if (h_bad) begin
        x_nxt = HS_X_NEXT;
      end else begin
        x_nxt = wrap_inc(x_rx, X_LAST);
        if (x_rx == X_LAST) y_nxt = wrap_inc(y_rx, Y_LAST);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      x_rx <= '0;
      y_rx <= '0;
    end else begin
      x_rx <= x_nxt;
      y_rx <= y_nxt;
    end
  end

  // Lock FSM.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= SEARCH;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      SEARCH:  if (v_fall) state_nxt = ARMED;
      ARMED: begin
        if (resync)    state_nxt = SEARCH;
        else if (v_ok) state_nxt = LOCKED;
      end
      LOCKED:  if (resync) state_nxt = SEARCH;
      default: state_nxt = SEARCH;
    endcase
  end

  // Error flags and count; a resync on the same clk as clr_err survives it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      h_err       <= 1'b0;
      v_err       <= 1'b0;
      error_count <= '0;
    end else begin
      h_err <= h_bad || (h_err && !clr_err);
      v_err <= v_bad || (v_err && !clr_err);
      if (resync)       error_count <= clr_err ? 8'd1 : sat_inc8(error_count);
      else if (clr_err) error_count <= '0;
    end
  end

  // Checksum. The accumulator is held at zero whenever not locked, so a frame
  // that loses lock part-way never publishes a partial sum.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc            <= '0;
      frame_checksum <= '0;
      frame_done     <= 1'b0;
    end else begin
      frame_done <= end_tick;
      if (!locked) begin
        acc <= '0;
      end else if (end_tick) begin
        frame_checksum <= acc + {4'b0, rgb};
        acc            <= '0;
      end else if (p_pixel && pix_valid) begin
        acc <= acc + {4'b0, rgb};
      end
    end
  end

endmodule

// File: tb/tb_vga_rx_monitor.sv
// Directed bench for vga_rx_monitor using a reduced 16x9 raster
// (8x4 active, hsync falls at x=10, vsync falls at y=6) and a tick every
// second clk. Expected values below are hand-computed for that raster.
module tb_vga_rx_monitor;

  localparam int HD = 8, HF = 2, HR = 4, HB = 2;
  localparam int VD = 4, VF = 2, VR = 1, VB = 2;
  localparam int HT = HD + HF + HR + HB;  // 16
  localparam int VT = VD + VF + VR + VB;  // 9
  localparam int HS = HD + HF;            // 10
  localparam int VS = VD + VF;            // 6

  logic        clk, reset, p_pixel, hsync, vsync, clr_err;
  logic [11:0] rgb;
  logic [9:0]  x_rx, y_rx;
  logic        locked, pix_valid, frame_done, h_err, v_err;
  logic [15:0] frame_checksum;
  logic [7:0]  error_count;

  int   compared = 0, mismatched = 0;
  int   gx = 0, gy = 0, hs_delay = 0, rgb_mode = 0, n = 0;
  logic hs_glitch = 1'b0, vs_glitch = 1'b0;
  logic fd_seen = 1'b0, lk_seen = 1'b0, fd_any = 1'b0;

  vga_rx_monitor #(
    .H_DISPLAY(HD), .H_FRONT(HF), .H_RETRACE(HR), .H_BACK(HB),
    .V_DISPLAY(VD), .V_FRONT(VF), .V_RETRACE(VR), .V_BACK(VB)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .p_pixel        (p_pixel),
    .hsync          (hsync),
    .vsync          (vsync),
    .rgb            (rgb),
    .clr_err        (clr_err),
    .x_rx           (x_rx),
    .y_rx           (y_rx),
    .locked         (locked),
    .pix_valid      (pix_valid),
    .frame_done     (frame_done),
    .frame_checksum (frame_checksum),
    .h_err          (h_err),
    .v_err          (v_err),
    .error_count    (error_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One pixel tick (one clk with p_pixel) followed by one idle clk.
  task automatic raw_tick(input logic h, input logic v);
    hsync   = h;
    vsync   = v;
    p_pixel = 1'b1;
    @(posedge clk); #1;
    p_pixel = 1'b0;
    clr_err = 1'b0;
    fd_seen = frame_done;
    lk_seen = locked;
    if (frame_done) fd_any = 1'b1;
    @(posedge clk); #1;
  endtask

  // Raster source: drives the sample for (gx,gy), then advances.
  task automatic tick();
    logic h, v;
    h = !((gx >= HS + hs_delay) && (gx < HS + HR));
    v = !((gy >= VS) && (gy < VS + VR));
    if (hs_glitch) h = 1'b0;
    if (vs_glitch) v = 1'b0;
    case (rgb_mode)
      0:       rgb = 12'hFFF;
      1:       rgb = (gx < HD && gy < VD) ? 12'h001 : 12'h000;
      default: rgb = (gx < HD && gy < VD) ? 12'(gx + 16 * gy) : 12'hFFF;
    endcase
    raw_tick(h, v);
    hs_glitch = 1'b0;
    vs_glitch = 1'b0;
    gx++;
    if (gx == HT) begin
      gx = 0;
      gy++;
      if (gy == VT) gy = 0;
    end
  endtask

  task automatic run_until(input int x, input int y);
    for (int i = 0; i < HT * VT && !(gx == x && gy == y); i++) tick();
  endtask

  task automatic wait_fd(output int cnt);
    cnt     = 0;
    fd_seen = 1'b0;
    while (!fd_seen && cnt < 300) begin
      tick();
      cnt++;
    end
  endtask

  initial begin
    reset = 1'b0; p_pixel = 1'b0; hsync = 1'b1; vsync = 1'b1;
    rgb = '0; clr_err = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_x", 32'(x_rx), 0);
    chk("rst_y", 32'(y_rx), 0);
    chk("rst_locked", 32'(locked), 0);
    chk("rst_pix_valid", 32'(pix_valid), 0);
    chk("rst_frame_done", 32'(frame_done), 0);
    chk("rst_cksum", 32'(frame_checksum), 0);
    chk("rst_errs", {h_err, v_err, error_count}, 0);
    reset = 1'b1;

    // Acquire lock on a clean stream, rgb = FFF everywhere.
    run_until(0, VS);
    chk("pre_vs1_locked", 32'(locked), 0);
    tick();
    chk("armed_locked", 32'(locked), 0);
    chk("armed_xy", {x_rx, y_rx}, {10'd1, 10'd6});
    chk("clean_errs", {h_err, v_err, error_count}, 0);
    run_until(0, VS);
    tick();
    chk("lock_after_vs2", 32'(locked), 1);
    chk("no_fd_before_lock", 32'(fd_any), 0);

    run_until(HD - 1, VD - 1);
    chk("last_px_xy", {x_rx, y_rx}, {10'd7, 10'd3});
    chk("last_px_valid", 32'(pix_valid), 1);
    tick();
    chk("fd_pulse", 32'(fd_seen), 1);
    chk("cksum_fff", 32'(frame_checksum), 32'hFFE0);
    chk("fd_one_clk", 32'(frame_done), 0);
    chk("blank_pix_valid", 32'(pix_valid), 0);

    wait_fd(n);
    chk("frame_period", n, HT * VT);
    chk("cksum_fff_2", 32'(frame_checksum), 32'hFFE0);

    rgb_mode = 1;
    wait_fd(n);
    chk("cksum_001", 32'(frame_checksum), 32'h0020);
    rgb_mode = 2;
    wait_fd(n);
    chk("cksum_ramp", 32'(frame_checksum), 32'h0370);

    // hsync fall delayed by 3 ticks on row 1 while locked.
    run_until(0, 1);
    chk("pre_hshift_locked", 32'(locked), 1);
    hs_delay = 3;
    run_until(HS + 3, 1);
    fd_any = 1'b0;
    tick();
    hs_delay = 0;
    chk("hshift_x", 32'(x_rx), HS + 1);
    chk("hshift_y", 32'(y_rx), 1);
    chk("hshift_locked_next_clk", 32'(lk_seen), 0);
    chk("hshift_errs", {h_err, v_err, error_count}, {1'b1, 1'b0, 8'd1});
    chk("hshift_cksum_hold", 32'(frame_checksum), 32'h0370);
    // Receiver now lags by 3; the next real hsync fall realigns it.
    run_until(HS + 1, 2);
    chk("hrealign_count", 32'(error_count), 2);
    chk("hrealign_xy", {x_rx, y_rx}, {10'd11, 10'd2});
    run_until(0, VS);
    tick();
    chk("hrelock_armed", 32'(locked), 0);
    run_until(0, VS);
    tick();
    chk("hrelock_locked", 32'(locked), 1);
    chk("hlost_no_fd", 32'(fd_any), 0);
    chk("hrelock_errs", {h_err, v_err, error_count}, {1'b1, 1'b0, 8'd2});

    // Stray vsync fall at row 2 while locked; source jumps along with it.
    run_until(3, 2);
    vs_glitch = 1'b1;
    fd_any    = 1'b0;
    tick();
    chk("vinj_xy", {x_rx, y_rx}, {10'd1, 10'd6});
    chk("vinj_errs", {v_err, error_count}, {1'b1, 8'd3});
    chk("vinj_locked", 32'(lk_seen), 0);
    chk("vinj_cksum_hold", 32'(frame_checksum), 32'h0370);
    gx = 1; gy = VS;
    run_until(0, VS);
    tick();
    run_until(0, VS);
    tick();
    chk("vrelock_locked", 32'(locked), 1);
    chk("vlost_no_fd", 32'(fd_any), 0);
    chk("vlost_cksum_hold", 32'(frame_checksum), 32'h0370);

    // clr_err alone.
    clr_err = 1'b1;
    @(posedge clk); #1;
    clr_err = 1'b0;
    chk("clr_errs", {h_err, v_err, error_count}, 0);

    // Simultaneous bad h and v edges: vsync realignment wins, one count.
    run_until(3, 1);
    hs_glitch = 1'b1;
    vs_glitch = 1'b1;
    tick();
    chk("hv_xy", {x_rx, y_rx}, {10'd1, 10'd6});
    chk("hv_errs", {h_err, v_err, error_count}, {1'b1, 1'b1, 8'd1});
    gx = 1; gy = VS;

    // clr_err coinciding with a bad hsync.
    run_until(3, 2);
    hs_glitch = 1'b1;
    clr_err   = 1'b1;
    tick();
    chk("clr_vs_event_errs", {h_err, v_err, error_count}, {1'b1, 1'b0, 8'd1});
    chk("clr_vs_event_x", 32'(x_rx), HS + 1);
    gx = HS + 1;

    // Asynchronous reset mid-frame while locked.
    run_until(0, VS);
    tick();
    run_until(0, VS);
    tick();
    chk("pre_rst_locked", 32'(locked), 1);
    run_until(2, 1);
    chk("pre_rst_pix_valid", 32'(pix_valid), 1);
    #2 reset = 1'b0;
    #1;
    chk("arst_xy", {x_rx, y_rx}, 0);
    chk("arst_lock_pv", {locked, pix_valid, frame_done}, 0);
    chk("arst_cksum", 32'(frame_checksum), 0);
    chk("arst_errs", {h_err, v_err, error_count}, 0);
    @(posedge clk); #1;
    reset = 1'b1;
    chk("post_rst_search", 32'(locked), 0);

    // Saturation: every low pulse on hsync is misplaced.
    for (int i = 0; i < 254; i++) begin
      raw_tick(1'b0, 1'b1);
      raw_tick(1'b1, 1'b1);
    end
    chk("count_254", 32'(error_count), 8'hFE);
    for (int i = 0; i < 46; i++) begin
      raw_tick(1'b0, 1'b1);
      raw_tick(1'b1, 1'b1);
    end
    chk("count_sat", 32'(error_count), 8'hFF);
    chk("sat_flags", {h_err, v_err}, 2'b10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
